// File: rtl/fetch_aligner.sv
// Halfword realignment buffer between the fetch port and the RV32IC decoder.
// Holds up to four halfwords and presents one 16- or 32-bit instruction at a time.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        word_valid_i,
  input  logic [31:0] word_i,
  output logic        word_ready_o,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic        instr_is_c_o,
  output logic [31:0] instr_pc_o,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i
);

  localparam int unsigned HW_W  = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic [HW_W-1:0]  hw_q  [DEPTH];
  logic [HW_W-1:0]  hw_sh [DEPTH];
  logic [HW_W-1:0]  hw_d  [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d, pop_n, rem;
  logic [31:0]      pc_q, pc_d;
  logic             drop_q, drop_d;
  logic             is_c, pop, push;

  assign is_c          = hw_q[0][1:0] != 2'b11;
  assign instr_valid_o = (cnt_q >= CNT_W'(1) && is_c) || (cnt_q >= CNT_W'(2) && !is_c);
  assign instr_is_c_o  = instr_valid_o && is_c;
  assign instr_o       = !instr_valid_o ? 32'h0 :
                         is_c ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
  assign instr_pc_o    = pc_q;
  assign word_ready_o  = (cnt_q <= CNT_W'(2)) && !flush_i;
  assign pop           = instr_valid_o && instr_ready_i && !flush_i;
  assign push          = word_valid_i && word_ready_o;

  // Pop shifts the FIFO first; pushed halfwords land after the survivors.
  always_comb begin
    pop_n  = '0;
    hw_sh  = hw_q;
    rem    = cnt_q;
    hw_d   = hw_q;
    cnt_d  = cnt_q;
    pc_d   = pc_q;
    drop_d = drop_q;

    if (pop) pop_n = is_c ? CNT_W'(1) : CNT_W'(2);

    case (pop_n)
      CNT_W'(1): hw_sh = '{hw_q[1], hw_q[2], hw_q[3], 16'h0};
      CNT_W'(2): hw_sh = '{hw_q[2], hw_q[3], 16'h0, 16'h0};
      default:   hw_sh = hw_q;
    endcase

    rem   = cnt_q - pop_n;
    hw_d  = hw_sh;
    cnt_d = rem;
    pc_d  = pc_q + 32'({pop_n, 1'b0});

    // The cnt<=2 push gate keeps rem+1 within the FIFO.
    if (push) begin
      if (drop_q) begin
        hw_d[rem[1:0]] = word_i[31:16];
        cnt_d          = rem + CNT_W'(1);
        drop_d         = 1'b0;
      end else begin
        hw_d[rem[1:0]]         = word_i[15:0];
        hw_d[rem[1:0] + 2'd1]  = word_i[31:16];
        cnt_d                  = rem + CNT_W'(2);
      end
    end

    if (flush_i) begin
      cnt_d  = '0;
      pc_d   = {flush_pc_i[31:1], 1'b0};
      drop_d = flush_pc_i[1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hw_q   <= '{default: '0};
      cnt_q  <= '0;
      pc_q   <= RESET_PC;
      drop_q <= 1'b0;
    end else begin
      hw_q   <= hw_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed self-checking bench for fetch_aligner.
// Observed outputs are packed as {valid, is_c, instr, pc} and compared to hand-computed values.
module tb_fetch_aligner;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        word_valid_i;
  logic [31:0] word_i;
  logic        word_ready_o;
  logic        instr_ready_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic        instr_is_c_o;
  logic [31:0] instr_pc_o;
  logic        flush_i;
  logic [31:0] flush_pc_i;

  int vectors = 0;
  int miscompares = 0;
  logic [65:0] obs, exp;

  fetch_aligner dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .word_valid_i(word_valid_i), .word_i(word_i), .word_ready_o(word_ready_o),
    .instr_ready_i(instr_ready_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_is_c_o(instr_is_c_o), .instr_pc_o(instr_pc_o),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i)
  );

  always #5 clk_i = ~clk_i;
  assign obs = {instr_valid_o, instr_is_c_o, instr_o, instr_pc_o};

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    word_valid_i = 1'b0; word_i = 32'h0; instr_ready_i = 1'b0;
    flush_i = 1'b0; flush_pc_i = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    #2;
    exp = {1'b0, 1'b0, 32'h0, 32'h0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_out got=%h exp=%h", obs, exp);
    end
    vectors++;
    if (word_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got=%b exp=1", word_ready_o);
    end
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_full_word();
    do_reset();
    word_valid_i = 1'b1; word_i = 32'h00A00093; instr_ready_i = 1'b1;
    step();
    word_valid_i = 1'b0;
    exp = {1'b1, 1'b0, 32'h00A00093, 32'h0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL full_out got=%h exp=%h", obs, exp);
    end
    step();
    exp = {1'b0, 1'b0, 32'h0, 32'h4};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL full_after_pop got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_compressed_pair();
    do_reset();
    word_valid_i = 1'b1; word_i = 32'h45294501; instr_ready_i = 1'b1;
    step();
    word_valid_i = 1'b0;
    exp = {1'b1, 1'b1, 32'h00004501, 32'h0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL c_first got=%h exp=%h", obs, exp);
    end
    step();
    exp = {1'b1, 1'b1, 32'h00004529, 32'h2};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL c_second got=%h exp=%h", obs, exp);
    end
    step();
    exp = {1'b0, 1'b0, 32'h0, 32'h4};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL c_drained got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_straddle();
    do_reset();
    word_valid_i = 1'b1; word_i = 32'h00934505; instr_ready_i = 1'b1;
    step();
    word_valid_i = 1'b0;
    exp = {1'b1, 1'b1, 32'h00004505, 32'h0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL st_c got=%h exp=%h", obs, exp);
    end
    step();
    // lone upper half of a 32-bit instruction must not be presented
    exp = {1'b0, 1'b0, 32'h0, 32'h2};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL st_wait got=%h exp=%h", obs, exp);
    end
    word_valid_i = 1'b1; word_i = 32'h000100A0;
    step();
    word_valid_i = 1'b0;
    exp = {1'b1, 1'b0, 32'h00A00093, 32'h2};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL st_full got=%h exp=%h", obs, exp);
    end
    step();
    exp = {1'b1, 1'b1, 32'h00000001, 32'h6};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL st_tail got=%h exp=%h", obs, exp);
    end
    step();
    exp = {1'b0, 1'b0, 32'h0, 32'h8};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL st_drained got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_flush_drop();
    do_reset();
    flush_i = 1'b1; flush_pc_i = 32'h00000102;
    #1;
    vectors++;
    if (word_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fl_ready got=%b exp=0", word_ready_o);
    end
    step();
    flush_i = 1'b0;
    word_valid_i = 1'b1; word_i = 32'h45290001;
    step();
    word_valid_i = 1'b0;
    exp = {1'b1, 1'b1, 32'h00004529, 32'h102};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL fl_drop got=%h exp=%h", obs, exp);
    end
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    // drop flag must be clear: next word contributes both halves
    word_valid_i = 1'b1; word_i = 32'h45294501;
    step();
    word_valid_i = 1'b0;
    exp = {1'b1, 1'b1, 32'h00004501, 32'h104};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL fl_dropclr got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_instr [4];
    exp_instr = '{32'h00004501, 32'h00004529, 32'h00004501, 32'h00004529};
    do_reset();
    word_valid_i = 1'b1; word_i = 32'h45294501;
    step();
    vectors++;
    if (word_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready2 got=%b exp=1", word_ready_o);
    end
    step();
    vectors++;
    if (word_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full got=%b exp=0", word_ready_o);
    end
    word_i = 32'h12345678;
    step();
    word_valid_i = 1'b0;
    exp = {1'b1, 1'b1, 32'h00004501, 32'h0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL bp_hold got=%h exp=%h", obs, exp);
    end
    instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = {1'b1, 1'b1, exp_instr[i], 32'(2 * i)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL bp_drain%0d got=%h exp=%h", i, obs, exp);
      end
      step();
    end
    exp = {1'b0, 1'b0, 32'h0, 32'h8};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL bp_empty got=%h exp=%h", obs, exp);
    end
    instr_ready_i = 1'b0;
  endtask

  task automatic test_flush_priority();
    do_reset();
    word_valid_i = 1'b1; word_i = 32'h45294501;
    step();
    instr_ready_i = 1'b1;
    step();
    word_valid_i = 1'b0; instr_ready_i = 1'b0;
    // cnt=3 here: 4529,4501,4529 at pc 2
    exp = {1'b1, 1'b1, 32'h00004529, 32'h2};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL fp_setup got=%h exp=%h", obs, exp);
    end
    flush_i = 1'b1; flush_pc_i = 32'h00000200;
    word_valid_i = 1'b1; word_i = 32'hDEADBEEF; instr_ready_i = 1'b1;
    step();
    flush_i = 1'b0; word_valid_i = 1'b0; instr_ready_i = 1'b0;
    #1;
    exp = {1'b0, 1'b0, 32'h0, 32'h200};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL fp_after got=%h exp=%h", obs, exp);
    end
    vectors++;
    if (word_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL fp_ready got=%b exp=1", word_ready_o);
    end
    flush_i = 1'b1; flush_pc_i = 32'h00000305;
    step();
    flush_i = 1'b0;
    word_valid_i = 1'b1; word_i = 32'h45294501;
    step();
    word_valid_i = 1'b0;
    exp = {1'b1, 1'b1, 32'h00004501, 32'h304};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL fp_odd got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    flush_i = 1'b1; flush_pc_i = 32'hFFFFFFFE;
    step();
    flush_i = 1'b0;
    word_valid_i = 1'b1; word_i = 32'h45010000;
    step();
    word_valid_i = 1'b0;
    exp = {1'b1, 1'b1, 32'h00004501, 32'hFFFFFFFE};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL wrap_out got=%h exp=%h", obs, exp);
    end
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    exp = {1'b0, 1'b0, 32'h0, 32'h0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL wrap_pc got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    word_valid_i = 1'b1; word_i = 32'h00A00093;
    step();
    word_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    exp = {1'b0, 1'b0, 32'h0, 32'h0};
    vectors++;
    if (obs !== exp || word_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset got=%h rdy=%b exp=%h rdy=1", obs, word_ready_o, exp);
    end
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    test_reset();
    test_full_word();
    test_compressed_pair();
    test_straddle();
    test_flush_drop();
    test_back_to_back();
    test_flush_priority();
    test_pc_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_aligner.md
# fetch_aligner

Halfword realignment buffer between the instruction-memory fetch port and the compressed-instruction decoder in the 5-stage RV32IC pipeline. It accepts word-aligned 32-bit fetch words and extracts one instruction per pop, either 16-bit compressed or 32-bit, at the correct PC. It tracks the PC and handles 32-bit instructions that straddle word boundaries. On a branch or jump redirect it flushes and restarts at any halfword-aligned PC.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bits [1:0] must be 0.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- word_valid_i  in  1  fetch word present.
- word_i  in  32  fetch word. The lower-address halfword is in [15:0].
- word_ready_o  out  1  the buffer can take a word this cycle.
- instr_ready_i  in  1  the decode stage accepts the instruction.
- instr_valid_o  out  1  a complete instruction is available.
- instr_o  out  32  raw instruction: {16'b0, hw0} if compressed, else {hw1, hw0}.
- instr_is_c_o  out  1  1 means 16-bit instruction.
- instr_pc_o  out  32  PC of instr_o.
- flush_i  in  1  redirect; takes priority over push and pop.
- flush_pc_i  in  32  redirect target; bit [0] is ignored.

## Operation
- State:
  - hw[0..3], 16 bits each, a FIFO of halfwords with hw[0] oldest.
  - cnt, 0..4.
  - pc_q, 32 bits.
  - drop_q, 1 bit.
- Compressed test: hw[0][1:0] != 2'b11.
- instr_valid_o = (cnt>=1 && compressed) || (cnt>=2 && !compressed).
- When instr_valid_o is 0, instr_o and instr_is_c_o are 0.
- instr_pc_o = pc_q at all times.
- word_ready_o = (cnt <= 2) && !flush_i. It depends on registered state and flush_i only, with no path from instr_ready_i.
- Pop = instr_valid_o && instr_ready_i && !flush_i.
  - Compressed: removes 1 halfword and adds 2 to pc_q.
  - Full: removes 2 halfwords and adds 4 to pc_q.
  - pc_q arithmetic is modulo 2^32.
- Push = word_valid_i && word_ready_o.
  - When drop_q=0: appends word_i[15:0], then word_i[31:16].
  - When drop_q=1: appends only word_i[31:16] and clears drop_q.
- Push and pop in the same cycle both take effect.
  - Pop shifts first; the pushed halfwords land after the remaining entries.
  - cnt_next = cnt - popped + pushed, never exceeding 4. The cnt<=2 gate guarantees this.
- Flush (flush_i=1):
  - cnt <= 0.
  - pc_q <= {flush_pc_i[31:1], 1'b0}.
  - drop_q <= flush_pc_i[1].
  - Any word presented that cycle is discarded; word_ready_o is 0.
  - The upstream fetch restarts at word address {flush_pc_i[31:2], 2'b00} from the next cycle.
- Any halfword pair with hw[0][1:0]==11 is treated as 32-bit, including reserved 48-bit encodings. Illegal-encoding detection belongs to the decoder.

## Timing
- Reset values: cnt=0, pc_q=RESET_PC, drop_q=0, hw[*]=0.
  - Outputs in reset: instr_valid_o=0, instr_o=0, instr_is_c_o=0, instr_pc_o=RESET_PC, word_ready_o=1.
- Reset asserted mid-operation clears all state immediately (asynchronously). Any instruction then presented is lost, with no partial output.
- Latency: a word accepted at edge N yields instr_valid_o in the cycle after edge N, provided it completes an instruction.
- Throughput: one instruction per cycle while words keep arriving.
  - A stream of compressed instructions drains 2 per word.
  - When the consumer stalls, the buffer fills to 4 halfwords and stops accepting.
- Outputs hold stable while instr_valid_o=1 and instr_ready_i=0. There is no flush in this case.
- instr_valid_o drops to 0 in the cycle after a flush edge.
- With flush_i=1 and instr_ready_i=1 in the same cycle, nothing pops.
- Straddling 32-bit instruction: with cnt=1 and hw[0] non-compressed, instr_valid_o stays 0 until the next word is pushed.

## Test plan
- Reset, then push 0x00A00093 → next cycle: valid=1, instr_o=0x00A00093, is_c=0, pc=0x0. After the pop: cnt=0, valid=0.
- Push 0x45294501 with ready high → 0x00004501 at pc 0x0 with is_c=1, then 0x00004529 at pc 0x2, on consecutive cycles.
- Push 0x00934505, then 0x000100A0 → three instructions:
  - 0x00004505 at pc 0x0 (is_c=1).
  - 0x00A00093 at pc 0x2 (is_c=0).
  - 0x00000001 at pc 0x6 (is_c=1).
- Flush to 0x102, then push 0x45290001 → low halfword dropped; output 0x00004529 at pc 0x102; drop_q clears.
- Hold instr_ready_i=0 and push 0x45294501 twice → word_ready_o=0 after the second push (cnt=4), and a third word is stalled. Release → 0x4501, 0x4529, 0x4501, 0x4529 at pc 0, 2, 4, 6, none lost.
- With cnt=3, assert flush_i to 0x200 together with word_valid_i and instr_ready_i → no pop, word discarded. Next cycle: valid=0, pc=0x200, word_ready_o=1. Also assert rst_i mid-stream → outputs return to their reset values immediately.
